// File: rtl/regfile_pkg.sv
// Shared encodings and named register addresses for the multi-port register file.
package regfile_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_NOP  = 2'b11
  } wr_op_e;

  // {hb,lb} lane select
  typedef enum logic [1:0] {
    LANE_NONE = 2'b00,
    LANE_LO   = 2'b01,
    LANE_HI   = 2'b10,
    LANE_FULL = 2'b11
  } lane_e;

  localparam logic [4:0] REG_AX1  = 5'd0;
  localparam logic [4:0] REG_BX1  = 5'd1;
  localparam logic [4:0] REG_CX1  = 5'd2;
  localparam logic [4:0] REG_DX1  = 5'd3;
  localparam logic [4:0] REG_AH1  = 5'd4;
  localparam logic [4:0] REG_BH1  = 5'd5;
  localparam logic [4:0] REG_CH1  = 5'd6;
  localparam logic [4:0] REG_DH1  = 5'd7;
  localparam logic [4:0] REG_AX2  = 5'd8;
  localparam logic [4:0] REG_BX2  = 5'd9;
  localparam logic [4:0] REG_CX2  = 5'd10;
  localparam logic [4:0] REG_DX2  = 5'd11;
  localparam logic [4:0] REG_AH2  = 5'd12;
  localparam logic [4:0] REG_BH2  = 5'd13;
  localparam logic [4:0] REG_CH2  = 5'd14;
  localparam logic [4:0] REG_DH2  = 5'd15;
  localparam logic [4:0] REG_SP   = 5'd16;
  localparam logic [4:0] REG_BP   = 5'd17;
  localparam logic [4:0] REG_RADR = 5'd18;
  localparam logic [4:0] REG_RLI  = 5'd19;

endpackage

// File: rtl/regfile_lane_alu.sv
// Combinational lane-aware load/inc/dec; untouched lanes pass through unchanged.
module regfile_lane_alu
  import regfile_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] old_word,
  input  lane_e            lane,
  input  wr_op_e           op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] new_word,
  output logic             carry,
  output logic             zero
);

  localparam int H = WIDTH / 2;

  // Extra top bit of each result captures carry/borrow; lanes never chain.
  logic [H:0]     lo_res, hi_res;
  logic [WIDTH:0] full_res;

  always_comb begin
    lo_res   = {1'b0, old_word[H-1:0]};
    hi_res   = {1'b0, old_word[WIDTH-1:H]};
    full_res = {1'b0, old_word};
    case (op)
      OP_LOAD: begin
        lo_res   = {1'b0, data[H-1:0]};
        hi_res   = {1'b0, data[H-1:0]};
        full_res = {1'b0, data};
      end
      OP_INC: begin
        lo_res   = {1'b0, old_word[H-1:0]} + (H+1)'(1);
        hi_res   = {1'b0, old_word[WIDTH-1:H]} + (H+1)'(1);
        full_res = {1'b0, old_word} + (WIDTH+1)'(1);
      end
      OP_DEC: begin
        lo_res   = {1'b0, old_word[H-1:0]} - (H+1)'(1);
        hi_res   = {1'b0, old_word[WIDTH-1:H]} - (H+1)'(1);
        full_res = {1'b0, old_word} - (WIDTH+1)'(1);
      end
      default: ;
    endcase

    new_word = old_word;
    carry    = 1'b0;
    zero     = 1'b0;
    if (op != OP_NOP) begin
      case (lane)
        LANE_LO: begin
          new_word[H-1:0] = lo_res[H-1:0];
          carry           = lo_res[H];
          zero            = (lo_res[H-1:0] == '0);
        end
        LANE_HI: begin
          new_word[WIDTH-1:H] = hi_res[H-1:0];
          carry               = hi_res[H];
          zero                = (hi_res[H-1:0] == '0);
        end
        LANE_FULL: begin
          new_word = full_res[WIDTH-1:0];
          carry    = full_res[WIDTH];
          zero     = (full_res[WIDTH-1:0] == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-lane access and in-place inc/dec.
// Define REGFILE_BYPASS_EN to forward a same-edge write into matching reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NRD-1:0]       rd_en,
  input  logic [NRD*AW-1:0]    rd_addr,
  input  logic [NRD*2-1:0]     rd_lane,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_valid,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [1:0]           wr_lane,
  input  logic [1:0]           wr_op,
  input  logic [WIDTH-1:0]     wr_data,
  output logic [WIDTH-1:0]     wr_result,
  output logic                 wr_carry,
  output logic                 wr_zero,
  output logic                 wr_done
);

  localparam int H = WIDTH / 2;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok, wr_commit;
  logic [WIDTH-1:0] wr_cur, alu_word;
  logic             alu_carry, alu_zero;

  assign wr_ok     = int'(wr_addr) < DEPTH;
  assign wr_cur    = wr_ok ? regs[wr_addr] : '0;
  assign wr_commit = en && wr_en && wr_ok && (wr_op != OP_NOP) && (wr_lane != LANE_NONE);

  regfile_lane_alu #(.WIDTH(WIDTH)) u_alu (
    .old_word (wr_cur),
    .lane     (lane_e'(wr_lane)),
    .op       (wr_op_e'(wr_op)),
    .data     (wr_data),
    .new_word (alu_word),
    .carry    (alu_carry),
    .zero     (alu_zero)
  );

  function automatic logic [WIDTH-1:0] read_word(input logic [AW-1:0] a);
    logic [WIDTH-1:0] w;
    w = '0;
    if (int'(a) < DEPTH) begin
      w = regs[a];
`ifdef REGFILE_BYPASS_EN
      // alu_word already holds the untouched lane, so this is the per-lane merge
      if (wr_commit && a == wr_addr) w = alu_word;
`endif
    end
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] lane_fmt(input logic [WIDTH-1:0] w, input logic [1:0] l);
    case (l)
      LANE_LO:   return {{H{1'b0}}, w[H-1:0]};
      LANE_HI:   return {{H{1'b0}}, w[WIDTH-1:H]};
      LANE_FULL: return w;
      default:   return '0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      wr_result <= '0;
      wr_carry  <= 1'b0;
      wr_zero   <= 1'b0;
      wr_done   <= 1'b0;
    end else if (en) begin
      wr_done <= wr_en;
      if (wr_en) begin
        wr_result <= wr_ok ? alu_word : '0;
        wr_carry  <= wr_ok && alu_carry;
        wr_zero   <= wr_ok && alu_zero;
      end
      if (wr_commit) regs[wr_addr] <= alu_word;
    end else begin
      wr_done <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= '0;
    end else if (en) begin
      for (int p = 0; p < NRD; p++) begin
        rd_valid[p] <= rd_en[p];
        if (rd_en[p])
          rd_data[p*WIDTH +: WIDTH] <= lane_fmt(read_word(rd_addr[p*AW +: AW]), rd_lane[p*2 +: 2]);
      end
    end else begin
      rd_valid <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed plus randomized bench for regfile_mp against a word-array reference model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst, en, wr_en;
  logic [1:0]  rd_en, rd_valid, wr_lane, wr_op;
  logic [9:0]  rd_addr;
  logic [3:0]  rd_lane;
  logic [31:0] rd_data;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data, wr_result;
  logic        wr_carry, wr_zero, wr_done;

  int checks = 0;
  int failures = 0;

  logic [15:0] mdl [32];
  logic [15:0] exp_rd [2];
  logic [1:0]  exp_vld;
  logic [15:0] exp_res;
  logic        exp_c, exp_z, exp_done;

  regfile_mp dut (
    .clk(clk), .rst(rst), .en(en),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_lane(rd_lane),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_lane(wr_lane), .wr_op(wr_op),
    .wr_data(wr_data), .wr_result(wr_result), .wr_carry(wr_carry),
    .wr_zero(wr_zero), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Field arithmetic straight from the lane rules: mask/offset, modular add.
  task automatic model_op(input logic [15:0] old, input logic [1:0] lane, input logic [1:0] op,
                          input logic [15:0] d, output logic [15:0] nw, output logic c,
                          output logic z);
    int unsigned o, off, mask, f, r;
    nw = old; c = 1'b0; z = 1'b0;
    if (lane == 2'b00 || op == 2'b11) return;
    o    = 32'(old);
    off  = (lane == 2'b10) ? 8 : 0;
    mask = (lane == 2'b11) ? 32'hFFFF : 32'hFF;
    f    = (o >> off) & mask;
    case (op)
      2'b00:   r = 32'(d) & mask;
      2'b01:   begin r = (f + 1) & mask; c = (f == mask); end
      default: begin r = (f + mask) & mask; c = (f == 0); end
    endcase
    nw = 16'((o & ~(mask << off)) | (r << off));
    z  = (r == 0);
  endtask

  function automatic logic [15:0] fmt(input logic [15:0] w, input logic [1:0] l);
    case (l)
      2'b01:   return {8'h00, w[7:0]};
      2'b10:   return {8'h00, w[15:8]};
      2'b11:   return w;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic idle();
    rst = 1'b0; en = 1'b1; wr_en = 1'b0; rd_en = 2'b00;
  endtask

  task automatic wr(input logic [4:0] a, input logic [1:0] l, input logic [1:0] o, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_lane = l; wr_op = o; wr_data = d;
  endtask

  task automatic rd(input int p, input logic [4:0] a, input logic [1:0] l);
    rd_en[p] = 1'b1; rd_addr[p*5 +: 5] = a; rd_lane[p*2 +: 2] = l;
  endtask

  // Predict from pre-edge model state, clock once, compare every output.
  task automatic step();
    logic [15:0] nw, w;
    logic [4:0]  ra;
    logic        c, z;
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 16'h0;
      exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
      exp_vld = 2'b00; exp_res = 16'h0; exp_c = 1'b0; exp_z = 1'b0; exp_done = 1'b0;
    end else if (en) begin
      nw = mdl[wr_addr]; c = 1'b0; z = 1'b0;
      if (wr_en) model_op(mdl[wr_addr], wr_lane, wr_op, wr_data, nw, c, z);
      for (int p = 0; p < 2; p++) begin
        exp_vld[p] = rd_en[p];
        if (rd_en[p]) begin
          ra = rd_addr[p*5 +: 5];
          w  = mdl[ra];
`ifdef REGFILE_BYPASS_EN
          if (wr_en && ra == wr_addr) w = nw;
`endif
          exp_rd[p] = fmt(w, rd_lane[p*2 +: 2]);
        end
      end
      exp_done = wr_en;
      if (wr_en) begin
        exp_res = nw; exp_c = c; exp_z = z;
        mdl[wr_addr] = nw;
      end
    end else begin
      exp_vld = 2'b00; exp_done = 1'b0;
    end
    @(posedge clk); #1;
    chk("wr_done",   32'(wr_done),   32'(exp_done));
    chk("wr_result", 32'(wr_result), 32'(exp_res));
    chk("wr_carry",  32'(wr_carry),  32'(exp_c));
    chk("wr_zero",   32'(wr_zero),   32'(exp_z));
    chk("rd_valid",  32'(rd_valid),  32'(exp_vld));
    chk("rd_data0",  32'(rd_data[15:0]),  32'(exp_rd[0]));
    chk("rd_data1",  32'(rd_data[31:16]), 32'(exp_rd[1]));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; rd_en = 2'b00;
    rd_addr = '0; rd_lane = '0; wr_addr = '0; wr_lane = '0; wr_op = '0; wr_data = '0;

    step();
    chk("reset_result", 32'(wr_result), 32'h0);
    chk("reset_valid", 32'(rd_valid), 32'h0);

    for (int a = 0; a < 32; a++) begin
      idle(); rd(0, 5'(a), 2'b11); rd(1, 5'(a), 2'b11);
      step();
      chk("sweep_valid", 32'(rd_valid), 32'h3);
      chk("sweep_data", rd_data, 32'h0);
    end

    idle(); wr(5'd5, 2'b11, 2'b00, 16'hA55A); step();
    chk("load_a55a", 32'(wr_result), 32'hA55A);
    idle(); rd(0, 5'd5, 2'b01); rd(1, 5'd5, 2'b10); step();
    chk("rd_lo", 32'(rd_data[15:0]), 32'h005A);
    chk("rd_hi", 32'(rd_data[31:16]), 32'h00A5);
    idle(); rd(0, 5'd5, 2'b11); step();
    chk("rd_full", 32'(rd_data[15:0]), 32'hA55A);

    idle(); wr(5'd3, 2'b11, 2'b00, 16'h3C00); step();
    idle(); wr(5'd3, 2'b01, 2'b00, 16'h00FF); step();
    idle(); wr(5'd3, 2'b01, 2'b01, 16'h0000); step();
    chk("lo_inc_word", 32'(wr_result), 32'h3C00);
    chk("lo_inc_carry", 32'(wr_carry), 32'h1);
    chk("lo_inc_zero", 32'(wr_zero), 32'h1);

    idle(); wr(5'd13, 2'b11, 2'b10, 16'h0000); step();
    chk("dec_word", 32'(wr_result), 32'hFFFF);
    chk("dec_borrow", 32'(wr_carry), 32'h1);
    chk("dec_zero", 32'(wr_zero), 32'h0);
    idle(); wr(5'd13, 2'b11, 2'b01, 16'h0000); step();
    chk("inc_wrap", 32'(wr_result), 32'h0000);
    chk("inc_carry", 32'(wr_carry), 32'h1);
    chk("inc_zero", 32'(wr_zero), 32'h1);

    idle(); wr(5'd7, 2'b11, 2'b00, 16'hBEEF); step();
    idle(); wr(5'd7, 2'b11, 2'b00, 16'h1234); rd(1, 5'd7, 2'b11); step();
`ifdef REGFILE_BYPASS_EN
    chk("same_edge", 32'(rd_data[31:16]), 32'h1234);
`else
    chk("same_edge", 32'(rd_data[31:16]), 32'hBEEF);
`endif
    idle(); wr(5'd7, 2'b01, 2'b00, 16'h0056); rd(0, 5'd7, 2'b11); step();
    idle(); wr(5'd7, 2'b11, 2'b11, 16'hFFFF); step();
    chk("nop_done", 32'(wr_done), 32'h1);
    chk("nop_carry", 32'(wr_carry), 32'h0);

    idle(); wr(5'd9, 2'b11, 2'b00, 16'h5555); rd(0, 5'd9, 2'b11); rst = 1'b1; step();
    idle(); en = 1'b0; wr(5'd9, 2'b11, 2'b00, 16'h7777); rd(0, 5'd9, 2'b11); step();
    chk("rst_en0_done", 32'(wr_done), 32'h0);
    chk("rst_en0_valid", 32'(rd_valid), 32'h0);
    idle(); rd(0, 5'd9, 2'b11); step();
    chk("rst_reg9", 32'(rd_data[15:0]), 32'h0);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 9) != 0);
      wr_en   = $urandom_range(0, 1) == 1;
      wr_addr = 5'($urandom_range(0, 31));
      wr_lane = 2'($urandom_range(0, 3));
      wr_op   = 2'($urandom_range(0, 3));
      wr_data = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      for (int p = 0; p < 2; p++) begin
        rd_en[p] = $urandom_range(0, 2) != 0;
        rd_addr[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom_range(0, 31));
        rd_lane[p*2 +: 2] = 2'($urandom_range(0, 3));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
